muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle multiply/divide sequencer that time-shares the 16-bit ALU.
//  Accepts one op at a time, drives the ALU operand/control pins each cycle, and
//  folds ALU sum/carry into internal accumulators. Result is 32-bit product or 16-bit quotient+remainder.
//  Sits beside the CPU execute stage; the ALU is muxed to this block while busy=1.
// PARAMETERS
//  WIDTH   16   operand width; must equal ALU width (only 16 supported)
//  CNT_W   5    iteration counter width, $clog2(WIDTH)+1
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous active-high reset
//  start      in   1   launch op; sampled only in IDLE
//  op_div     in   1   0=multiply, 1=divide
//  op_signed  in   1   signed variant (ignored unless MULDIV_SIGNED_EN)
//  opa, opb   in   16  multiplicand/multiplier or dividend/divisor
//  busy       out  1   op in flight (PRE/ITER/POST)
//  done       out  1   one-cycle pulse, results valid
//  res_hi     out  16  product[31:16] | remainder
//  res_lo     out  16  product[15:0]  | quotient
//  dz         out  1   divide by zero flag, valid with done, held
//  alu_a, alu_b  out 16  ALU operands
//  alu_ci, alu_nb, alu_na, alu_ic, alu_xo, alu_no, alu_rot  out 1  ALU controls
//  alu_o      in   16  ALU result (same-cycle)
//  alu_cf     in   1   ALU carry out (same-cycle)
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge, any state incl. mid-op): state=IDLE; busy, done, dz,
//   res_hi, res_lo, all alu_* outputs = 0; counters cleared. In-flight op is dropped.
//  States: IDLE -> [PRE] -> ITER(x16) -> [POST] -> DONE -> IDLE. DONE lasts 1 cycle.
//  start in IDLE at cycle T latches opa/opb/op; start in any other state ignored (no queue).
//  Latency unsigned: ITER T+1..T+16, done=1 at T+17. busy=1 exactly T+1..T+16.
//  ALU micro-ops: ADD a+b (nb=0,ci=0); SUB a-b (nb=1,ci=1, cf=1 means no borrow);
//   PASS a+0 (alu_b=0); NEG ~a+ci (na=1,b=0,ci=1). ic,xo,no,rot always 0. IDLE/DONE: all 0.
//  MUL iter: alu_a=acc_hi, alu_b = lo[0] ? mcand : 0 (ADD); {acc_hi,lo} <= {alu_cf,alu_o,lo}>>1.
//  DIV iter (restoring): r17={r,q[15]}, q<<=1; alu_a=r17[15:0], alu_b=divisor (SUB);
//   if r17[16] | alu_cf: r<=alu_o, q[0]<=1 else r<=r17[15:0], q[0]<=0.
//  Divide by zero: no special path; iteration yields q=0xFFFF, r=dividend; dz=1. Same latency.
//  res_hi/res_lo/dz update only in DONE cycle; held until next DONE or reset.
//  Counter counts 0..15 in ITER; exits on 15, no wrap.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined: op_signed=1 selects two's-complement ops. PRE (2 cycles):
//   NEG-or-PASS opa then opb by sign bit. POST (2 cycles): MUL negates lo then hi
//   (hi ci = lo cf) if a15^b15; DIV negates q if a15^b15, r if a15. PRE/POST always run
//   when op_signed=1: done at T+21, busy T+1..T+20. dz from original divisor;
//   -32768/-1 gives q=0x8000, r=0. Unsigned ops keep 17-cycle latency.
//  Undefined: op_signed ignored, PRE/POST states absent, all ops unsigned.
// STRUCTURE
//  Package muldiv_pkg: state enum (IDLE,PRE0,PRE1,ITER,POST0,POST1,DONE), micro-op enum
//   (UOP_NONE,ADD,SUB,PASS,NEG), ITERS=16, struct alu_ctl_t of the 7 control bits.
//  Sub-module muldiv_alu_enc: combinational micro-op -> alu_ctl_t + alu_b forcing.
//  Bench instantiates real ALU between alu_* outputs and alu_o/alu_cf.
// TESTING
//  MUL 0x1234*0x0010 -> res_hi=0x0001, res_lo=0x2340, done exactly 17 clk after start.
//  MUL 0xFFFF*0xFFFF -> res_hi=0xFFFE, res_lo=0x0001; carry path exercised every iter.
//  DIV 100/7 -> res_lo=14, res_hi=2, dz=0; DIV 0x1234/0 -> res_lo=0xFFFF, res_hi=0x1234, dz=1.
//  start pulses while busy and in DONE -> ignored; results of first op unchanged.
//  rst asserted at ITER 8 -> next cycle IDLE, all outputs 0; fresh start completes correctly.
//  MULDIV_SIGNED_EN: -3*5 -> 0xFFFF/0xFFF1; -7/2 -> q=0xFFFD, r=0xFFFF; done at T+21.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide sequencer: FSM states, ALU micro-ops
// and the bundle of ALU control pins.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE, PRE0, PRE1, ITER, POST0, POST1, DONE
  } state_t;

  typedef enum logic [2:0] {
    UOP_NONE, ADD, SUB, PASS, NEG
  } uop_t;

  localparam int ITERS = 16;

  typedef struct packed {
    logic ci;
    logic nb;
    logic na;
    logic ic;
    logic xo;
    logic no;
    logic rot;
  } alu_ctl_t;

endpackage

// File: rtl/muldiv_alu_enc.sv
// Combinational encoder from a sequencer micro-op to the ALU control pins,
// including forcing the B operand to zero for PASS/NEG.
module muldiv_alu_enc
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  uop_t             uop,
  input  logic [WIDTH-1:0] b_in,
  input  logic             neg_ci,
  output alu_ctl_t         ctl,
  output logic [WIDTH-1:0] b_out
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctl   = '0;
    b_out = '0;
    case (uop)
      ADD: b_out = b_in;
      SUB: begin
        ctl.nb = 1'b1;
        ctl.ci = 1'b1;
        b_out  = b_in;
      end
      NEG: begin
        ctl.na = 1'b1;
        ctl.ci = neg_ci;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer that borrows the shared 16-bit ALU.
// Signed operation (PRE/POST sign fix-up) is built only with MULDIV_SIGNED_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dz,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ci,
  output logic             alu_nb,
  output logic             alu_na,
  output logic             alu_ic,
  output logic             alu_xo,
  output logic             alu_no,
  output logic             alu_rot,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_cf
);

  state_t           state, state_nx;
  uop_t             uop;
  alu_ctl_t         ctl;
  logic [WIDTH-1:0] acc, lo, mreg;   // hi accumulator / remainder, multiplier / quotient, multiplicand / divisor
  logic [WIDTH-1:0] acc_d, lo_d, mreg_d, b_sel;
  logic [CNT_W-1:0] cnt;
  logic             is_div, dz_pend, neg_ci;
  logic             last_iter;

`ifdef MULDIV_SIGNED_EN
  logic is_signed, a_neg, b_neg, neg_c;
`else
  logic op_signed_unused;
  assign op_signed_unused = op_signed;
`endif

  assign last_iter = (cnt == CNT_W'(ITERS - 1));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
`ifdef MULDIV_SIGNED_EN
        state_nx = op_signed ? PRE0 : ITER;
`else
        state_nx = ITER;
`endif
      end
`ifdef MULDIV_SIGNED_EN
      PRE0:  state_nx = PRE1;
      PRE1:  state_nx = ITER;
      ITER:  if (last_iter) state_nx = is_signed ? POST0 : DONE;
      POST0: state_nx = POST1;
      POST1: state_nx = DONE;
`else
      ITER:  if (last_iter) state_nx = DONE;
`endif
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    uop    = UOP_NONE;
    alu_a  = '0;
    b_sel  = '0;
    neg_ci = 1'b1;
    case (state)
      ITER: begin
        busy = 1'b1;
        if (is_div) begin
          alu_a = {acc[WIDTH-2:0], lo[WIDTH-1]};
          b_sel = mreg;
          uop   = SUB;
        end else begin
          alu_a = acc;
          b_sel = lo[0] ? mreg : '0;
          uop   = ADD;
        end
      end
`ifdef MULDIV_SIGNED_EN
      PRE0: begin
        busy  = 1'b1;
        alu_a = is_div ? lo : mreg;
        uop   = a_neg ? NEG : PASS;
      end
      PRE1: begin
        busy  = 1'b1;
        alu_a = is_div ? mreg : lo;
        uop   = b_neg ? NEG : PASS;
      end
      POST0: begin
        busy  = 1'b1;
        alu_a = lo;
        uop   = (a_neg ^ b_neg) ? NEG : PASS;
      end
      POST1: begin
        // A 32-bit product negation ripples the low-half carry into the high half.
        busy   = 1'b1;
        alu_a  = acc;
        uop    = (is_div ? a_neg : (a_neg ^ b_neg)) ? NEG : PASS;
        neg_ci = is_div ? 1'b1 : neg_c;
      end
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  muldiv_alu_enc #(.WIDTH(WIDTH)) u_enc (
    .uop   (uop),
    .b_in  (b_sel),
    .neg_ci(neg_ci),
    .ctl   (ctl),
    .b_out (alu_b)
  );

  assign {alu_ci, alu_nb, alu_na, alu_ic, alu_xo, alu_no, alu_rot} = ctl;

  always_comb begin
    acc_d  = acc;
    lo_d   = lo;
    mreg_d = mreg;
    case (state)
      ITER: begin
        if (is_div) begin
          // Restoring step: keep the difference when the 17-bit partial remainder covers the divisor.
          acc_d = (acc[WIDTH-1] | alu_cf) ? alu_o : {acc[WIDTH-2:0], lo[WIDTH-1]};
          lo_d  = {lo[WIDTH-2:0], acc[WIDTH-1] | alu_cf};
        end else begin
          acc_d = {alu_cf, alu_o[WIDTH-1:1]};
          lo_d  = {alu_o[0], lo[WIDTH-1:1]};
        end
      end
`ifdef MULDIV_SIGNED_EN
      PRE0:  if (is_div) lo_d = alu_o; else mreg_d = alu_o;
      PRE1:  if (is_div) mreg_d = alu_o; else lo_d = alu_o;
      POST0: lo_d = alu_o;
      POST1: acc_d = alu_o;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      lo      <= '0;
      mreg    <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      dz_pend <= 1'b0;
      res_hi  <= '0;
      res_lo  <= '0;
      dz      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      is_signed <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      neg_c     <= 1'b0;
`endif
    end else begin
      acc  <= acc_d;
      lo   <= lo_d;
      mreg <= mreg_d;
      if (state == IDLE && start) begin
        acc     <= '0;
        lo      <= op_div ? opa : opb;
        mreg    <= op_div ? opb : opa;
        cnt     <= '0;
        is_div  <= op_div;
        dz_pend <= op_div & (opb == '0);
`ifdef MULDIV_SIGNED_EN
        is_signed <= op_signed;
        a_neg     <= op_signed & opa[WIDTH-1];
        b_neg     <= op_signed & opb[WIDTH-1];
`endif
      end
      if (state == ITER) cnt <= last_iter ? '0 : cnt + 1'b1;
`ifdef MULDIV_SIGNED_EN
      if (state == POST0) neg_c <= alu_cf;
`endif
      // Results are captured on entry to DONE so they are valid while done is high.
      if (state_nx == DONE) begin
        res_hi <= acc_d;
        res_lo <= lo_d;
        dz     <= dz_pend;
      end
    end
  end

endmodule
